end_game_overlay_ctrl: RTL and testbench
========================================

Name: end_game_overlay_ctrl

Overview:
- Sequences the end-game text sprite RAM during the game-over screen.
- Latches the winner after the game-over event, waits a set number of frames, then blinks the winner's text box at a fixed screen position.
- Each cycle, converts the VGA DrawX/DrawY position into a sprite select and pixel_addr for the RAM, plus a valid flag aligned with the RAM's data_out for the colour mapper.

Parameters:
- SPR_W, 240, sprite width in pixels
- SPR_H, 120, sprite height in pixels (SPR_W*SPR_H = 28800 words)
- ORIGIN_X, 200, screen X of the sprite's top-left pixel
- ORIGIN_Y, 180, screen Y of the sprite's top-left pixel
- DELAY_FRAMES, 30, frames between game_over and first display (>=1)
- BLINK_ON, 40, frames visible per blink period (>=1)
- BLINK_OFF, 20, frames hidden per blink period (>=1)

Ports:
- CLK  in  1  pixel clock
- RESET_N  in  1  reset, asynchronous, active-low
- game_over  in  1  single-cycle pulse: game ended
- winner  in  1  0 = black won, 1 = white won; sampled with game_over
- new_game  in  1  single-cycle pulse: leave end screen
- frame_start  in  1  single-cycle pulse, once per frame (start of vblank)
- DrawX  in  10  current pixel column
- DrawY  in  10  current pixel row
- select  out  2  to RAM: 01 black text, 10 white text, 00 none
- pixel_addr  out  15  to RAM: word address
- overlay_valid  out  1  RAM data_out is a valid overlay pixel this cycle
- overlay_active  out  1  controller is not IDLE
- winner_q  out  1  latched winner

Behaviour:
- Reset (async assert, sync release): state=IDLE, all counters 0, select=00, pixel_addr=0, overlay_valid=0, overlay_active=0, winner_q=0.
- States: IDLE, DELAY, SHOW_ON, SHOW_OFF. frame_cnt counts frame_start pulses in the current state.
- IDLE:
  - On game_over, go to DELAY with frame_cnt=0 and winner_q<=winner.
  - A frame_start in the same cycle is not counted.
- DELAY: each frame_start increments frame_cnt. At the frame_start that makes the count DELAY_FRAMES, go to SHOW_ON with frame_cnt=0.
- SHOW_ON: after BLINK_ON frame_starts, go to SHOW_OFF with frame_cnt=0.
- SHOW_OFF: after BLINK_OFF frame_starts, go to SHOW_ON with frame_cnt=0. Blinking repeats indefinitely.
- new_game: any state goes to IDLE next cycle, counters cleared. It has priority over game_over and frame_start in the same cycle. winner_q is held.
- game_over outside IDLE is ignored; winner_q is not updated.
- overlay_active = (state != IDLE), registered from state.
- Window hit: ORIGIN_X <= DrawX < ORIGIN_X+SPR_W and ORIGIN_Y <= DrawY < ORIGIN_Y+SPR_H, evaluated on the current DrawX/DrawY.
- Stage 1 (registered, 1 cycle after DrawX/DrawY):
  - If hit and state==SHOW_ON: pixel_addr <= (DrawY-ORIGIN_Y)*SPR_W + (DrawX-ORIGIN_X), computed in 15 bits (max 28799, no overflow); select <= winner_q ? 10 : 01.
  - Otherwise: select <= 00, pixel_addr <= 0.
- Stage 2: the RAM registers data_out one cycle later. overlay_valid is the stage-1 "select != 00" delayed one cycle, so it is asserted 2 cycles after the DrawX/DrawY sample, in the same cycle as the matching data_out.
- The colour mapper must ignore data_out whenever overlay_valid=0; the RAM drives X for select=00.
- State transitions mid-line: take effect on the next stage-1 evaluation. Pixels already in the pipeline complete with their old select and valid.
- No gating of DrawX/DrawY against blanking: any hit coordinate is processed.

Test Plan:
1. Reset assert mid-SHOW_ON with DrawX/DrawY inside the window -> select=00, pixel_addr=0, overlay_valid=0, overlay_active=0 immediately, without waiting for a clock edge.
2. Overrides DELAY_FRAMES=2, BLINK_ON=3, BLINK_OFF=2; game_over with winner=1, then 10 frame_start pulses -> state sequence DELAY,DELAY,SHOW_ON x3,SHOW_OFF x2,SHOW_ON..., changing on the 2nd, 5th and 7th pulses; select=10 only in SHOW_ON.
3. SHOW_ON, winner=0; drive DrawX=200,DrawY=180 then DrawX=439,DrawY=299 -> pixel_addr=0 then 28799; select=01; overlay_valid high 2 cycles after each sample.
4. SHOW_ON; drive DrawX=199,DrawY=180, then DrawX=440, then DrawY=300 -> select=00, overlay_valid=0 for all three (edge exclusion).
5. In DELAY, pulse game_over with winner=0 -> ignored, winner_q stays 1. Then new_game and frame_start in the same cycle -> IDLE next cycle, counters 0, overlay_active=0 one cycle later.
6. In IDLE, game_over and frame_start in the same cycle with DELAY_FRAMES=2 -> SHOW_ON only after 2 further frame_start pulses.

Source files
------------

// File: rtl/end_game_overlay_ctrl.sv
// End-game overlay sequencer: latches winner, waits, blinks text box.
// Ports: CLK/RESET_N, game_over/winner/new_game/frame_start, DrawX/DrawY in; select/pixel_addr/overlay_valid/overlay_active/winner_q out.
module end_game_overlay_ctrl #(
  parameter int SPR_W        = 240,
  parameter int SPR_H        = 120,
  parameter int ORIGIN_X     = 200,
  parameter int ORIGIN_Y     = 180,
  parameter int DELAY_FRAMES = 30,
  parameter int BLINK_ON     = 40,
  parameter int BLINK_OFF    = 20
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        game_over,
  input  logic        winner,
  input  logic        new_game,
  input  logic        frame_start,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  output logic [1:0]  select,
  output logic [14:0] pixel_addr,
  output logic        overlay_valid,
  output logic        overlay_active,
  output logic        winner_q
);

  localparam int MAXF_A = (DELAY_FRAMES > BLINK_ON) ? DELAY_FRAMES : BLINK_ON;
  localparam int MAXF   = (MAXF_A > BLINK_OFF) ? MAXF_A : BLINK_OFF;
  localparam int CW     = $clog2(MAXF + 1);

  localparam logic [11:0] X_LO = 12'(ORIGIN_X);
  localparam logic [11:0] X_HI = 12'(ORIGIN_X + SPR_W);
  localparam logic [11:0] Y_LO = 12'(ORIGIN_Y);
  localparam logic [11:0] Y_HI = 12'(ORIGIN_Y + SPR_H);

  localparam logic [CW-1:0] N_DLY = CW'(DELAY_FRAMES);
  localparam logic [CW-1:0] N_ON  = CW'(BLINK_ON);
  localparam logic [CW-1:0] N_OFF = CW'(BLINK_OFF);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    SHOW_ON,
    SHOW_OFF
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          win_d;

  logic          hit;
  logic [9:0]    dx, dy;
  logic [14:0]   addr;

  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    win_d   = winner_q;
    if (new_game) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // frame_start alongside game_over is deliberately not counted
          if (game_over) begin
            state_d = DELAY;
            cnt_d   = '0;
            win_d   = winner;
          end
        end
        DELAY: begin
          if (frame_start) begin
            if (cnt_inc == N_DLY) begin
              state_d = SHOW_ON;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        SHOW_ON: begin
          if (frame_start) begin
            if (cnt_inc == N_ON) begin
              state_d = SHOW_OFF;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        SHOW_OFF: begin
          if (frame_start) begin
            if (cnt_inc == N_OFF) begin
              state_d = SHOW_ON;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      winner_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      winner_q <= win_d;
    end
  end

  assign hit = ({2'b00, DrawX} >= X_LO) && ({2'b00, DrawX} < X_HI) &&
               ({2'b00, DrawY} >= Y_LO) && ({2'b00, DrawY} < Y_HI);

  assign dx   = DrawX - 10'(ORIGIN_X);
  assign dy   = DrawY - 10'(ORIGIN_Y);
  assign addr = 15'(dy) * 15'(SPR_W) + 15'(dx);

  // Stage 1 addresses the RAM; stage 2 (valid) lines up with its data_out
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      select         <= 2'b00;
      pixel_addr     <= '0;
      overlay_valid  <= 1'b0;
      overlay_active <= 1'b0;
    end else begin
      overlay_active <= (state_q != IDLE);
      overlay_valid  <= (select != 2'b00);
      if (hit && (state_q == SHOW_ON)) begin
        select     <= winner_q ? 2'b10 : 2'b01;
        pixel_addr <= addr;
      end else begin
        select     <= 2'b00;
        pixel_addr <= '0;
      end
    end
  end

endmodule

// File: tb/tb_end_game_overlay_ctrl.sv
// Bench for end_game_overlay_ctrl: directed scenarios plus random traffic
// checked every cycle against a frame-count reference model.
module tb_end_game_overlay_ctrl;

  localparam int SW  = 240;
  localparam int SH  = 120;
  localparam int OX  = 200;
  localparam int OY  = 180;
  localparam int DLY = 2;
  localparam int ON  = 3;
  localparam int OFF = 2;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        game_over = 1'b0;
  logic        winner = 1'b0;
  logic        new_game = 1'b0;
  logic        frame_start = 1'b0;
  logic [9:0]  DrawX = '0;
  logic [9:0]  DrawY = '0;
  logic [1:0]  select;
  logic [14:0] pixel_addr;
  logic        overlay_valid;
  logic        overlay_active;
  logic        winner_q;

  end_game_overlay_ctrl #(
    .SPR_W(SW), .SPR_H(SH), .ORIGIN_X(OX), .ORIGIN_Y(OY),
    .DELAY_FRAMES(DLY), .BLINK_ON(ON), .BLINK_OFF(OFF)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .game_over(game_over), .winner(winner),
    .new_game(new_game), .frame_start(frame_start),
    .DrawX(DrawX), .DrawY(DrawY),
    .select(select), .pixel_addr(pixel_addr),
    .overlay_valid(overlay_valid),
    .overlay_active(overlay_active),
    .winner_q(winner_q)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // reference model: "active" flag plus frames seen since game_over
  bit m_on;
  int m_fr;
  bit m_wq;
  int m_sel, m_addr;
  bit m_valid, m_act;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit showing();
    int k;
    if (!m_on || m_fr < DLY) return 1'b0;
    k = (m_fr - DLY) % (ON + OFF);
    return k < ON;
  endfunction

  task automatic model_reset();
    m_on = 0; m_fr = 0; m_wq = 0;
    m_sel = 0; m_addr = 0; m_valid = 0; m_act = 0;
  endtask

  task automatic model_clock();
    int x, y;
    bit h;
    x = int'(DrawX);
    y = int'(DrawY);
    h = (x >= OX) && (x < OX + SW) && (y >= OY) && (y < OY + SH);
    m_valid = (m_sel != 0);
    m_act   = m_on;
    if (h && showing()) begin
      m_sel  = m_wq ? 2 : 1;
      m_addr = (y - OY) * SW + (x - OX);
    end else begin
      m_sel  = 0;
      m_addr = 0;
    end
    if (new_game) begin
      m_on = 0; m_fr = 0;
    end else if (!m_on && game_over) begin
      m_on = 1; m_fr = 0; m_wq = winner;
    end else if (m_on && frame_start) begin
      m_fr++;
    end
  endtask

  task automatic check_all();
    chk("select", int'(select), m_sel);
    chk("pixel_addr", int'(pixel_addr), m_addr);
    chk("overlay_valid", int'(overlay_valid), int'(m_valid));
    chk("overlay_active", int'(overlay_active), int'(m_act));
    chk("winner_q", int'(winner_q), int'(m_wq));
  endtask

  task automatic step(input bit go, input bit w, input bit ng,
                      input bit fs, input int x, input int y);
    game_over   = go;
    winner      = w;
    new_game    = ng;
    frame_start = fs;
    DrawX       = 10'(x);
    DrawY       = 10'(y);
    @(posedge CLK);
    model_clock();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    #2;
    RESET_N = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge CLK);
    RESET_N = 1'b1;
  endtask

  bit exp_on [10] = '{0, 1, 1, 1, 0, 0, 1, 1, 1, 0};

  initial begin
    model_reset();
    #1;
    check_all();
    @(negedge CLK);
    RESET_N = 1'b1;
    @(posedge CLK);
    #1;

    // blink sequence with white winner
    step(1, 1, 0, 0, 300, 200);
    for (int p = 0; p < 10; p++) begin
      step(0, 0, 0, 1, 300, 200);
      step(0, 0, 0, 0, 300, 200);
      chk("blink_sel", int'(select), exp_on[p] ? 2 : 0);
    end

    // async reset with an in-window pixel in SHOW_ON
    do_reset();
    step(1, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 250, 200);
    step(0, 0, 0, 0, 250, 200);
    step(0, 0, 0, 0, 250, 200);
    chk("pre_reset_valid", int'(overlay_valid), 1);
    do_reset();
    chk("rst_sel", int'(select), 0);

    // corners with black winner
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, OX, OY);
    chk("corner_lo_sel", int'(select), 1);
    step(0, 0, 0, 0, OX + SW - 1, OY + SH - 1);
    chk("corner_hi_addr", int'(pixel_addr), SW * SH - 1);
    chk("corner_lo_valid", int'(overlay_valid), 1);
    step(0, 0, 0, 0, 0, 0);
    chk("corner_hi_valid", int'(overlay_valid), 1);

    // edge exclusion
    step(0, 0, 0, 0, OX - 1, OY);
    step(0, 0, 0, 0, OX + SW, OY);
    chk("edge_x_sel", int'(select), 0);
    step(0, 0, 0, 0, OX, OY + SH);
    chk("edge_y_sel", int'(select), 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // game_over ignored in DELAY, then new_game beats frame_start
    step(0, 0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("ignored_go_wq", int'(winner_q), 1);
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("ng_active", int'(overlay_active), 0);

    // game_over with frame_start in the same cycle
    step(1, 1, 0, 1, 300, 200);
    step(0, 0, 0, 1, 300, 200);
    step(0, 0, 0, 0, 300, 200);
    chk("go_fs_delay_sel", int'(select), 0);
    step(0, 0, 0, 1, 300, 200);
    step(0, 0, 0, 0, 300, 200);
    chk("go_fs_show_sel", int'(select), 2);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      int x, y;
      if ($urandom_range(1, 0) == 1) begin
        x = int'($urandom_range(450, 190));
        y = int'($urandom_range(310, 170));
      end else begin
        x = int'($urandom_range(1023, 0));
        y = int'($urandom_range(1023, 0));
      end
      step($urandom_range(39, 0) == 0, 1'($urandom),
           $urandom_range(299, 0) == 0, $urandom_range(5, 0) == 0,
           x, y);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
